// File: rtl/check_node_serial_if.sv
// Handshake bundle between the variable-node FIFOs and the serial check node.
interface check_node_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_beta;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_alpha;
  logic       out_last;
  logic       err;

  // Producer of betas / consumer of alphas
  modport master (
    output in_valid, in_beta, in_last, out_ready,
    input  in_ready, out_valid, out_alpha, out_last, err
  );

  // The check node itself
  modport slave (
    input  in_valid, in_beta, in_last, out_ready,
    output in_ready, out_valid, out_alpha, out_last, err
  );
endinterface

// File: rtl/check_node_serial.sv
// Serial offset-min-sum LDPC check node: collects one beta per cycle, then
// replays one alpha per cycle using min1/min2/idx and the sign parity.
module check_node_serial #(
  parameter int unsigned DEG_MAX = 8,
  parameter int unsigned OFFSET  = 0
) (
  input  logic                clk,
  input  logic                rst,
  check_node_serial_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEG_MAX + 1);
  localparam int unsigned IW = $clog2(DEG_MAX);
  localparam int unsigned MW = 5;
  localparam int unsigned BW = 6;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [MW-1:0]        min1;
  logic [MW-1:0]        min2;
  logic [IW-1:0]        idx;
  logic                 parity;
  logic [DEG_MAX-1:0]   sign_q;
  logic [IW-1:0]        k;
  logic                 out_valid_q;
  logic [BW-1:0]        out_alpha_q;
  logic                 out_last_q;
  logic                 err_q;

  logic                 accept;
  logic [BW-1:0]        neg_beta;
  logic [MW-1:0]        mag;
  logic [CW-1:0]        n_cnt;
  logic [MW-1:0]        n_min1;
  logic [MW-1:0]        n_min2;
  logic [IW-1:0]        n_idx;
  logic                 n_parity;
  logic [DEG_MAX-1:0]   n_sign;
  logic                 done;
  logic                 overflow;
  logic [IW-1:0]        k_next;
  logic                 next_is_last;

  // Apply offset and sign to the selected minimum; zero magnitude stays +0
  function automatic logic [BW-1:0] alpha_calc(input logic use_min2, input logic sgn,
                                               input logic [MW-1:0] m1, input logic [MW-1:0] m2);
    logic [MW-1:0] m;
    logic [MW-1:0] mo;
    m  = use_min2 ? m2 : m1;
    mo = (m > MW'(OFFSET)) ? m - MW'(OFFSET) : MW'(0);
    return sgn ? BW'(-{1'b0, mo}) : {1'b0, mo};
  endfunction

  assign bus.in_ready  = (state == COLLECT) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_alpha = out_alpha_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;

  assign accept = bus.in_valid && bus.in_ready;

  // Accumulator update for the beta being accepted this cycle
  always_comb begin
    neg_beta = BW'(-bus.in_beta);
    mag      = MW'(0);
    n_min1   = min1;
    n_min2   = min2;
    n_idx    = idx;
    n_sign   = sign_q;
    n_parity = parity ^ bus.in_beta[5];
    n_cnt    = cnt + CW'(1);
    if (bus.in_beta == 6'b100000) mag = MW'(31);
    else if (bus.in_beta[5])      mag = neg_beta[MW-1:0];
    else                          mag = bus.in_beta[MW-1:0];
    if (mag < min1) begin
      n_min2 = min1;
      n_min1 = mag;
      n_idx  = IW'(cnt);
    end else if (mag < min2) begin
      n_min2 = mag;
    end
    n_sign[IW'(cnt)] = bus.in_beta[5];
    overflow     = (n_cnt == CW'(DEG_MAX)) && !bus.in_last;
    done         = bus.in_last || (n_cnt == CW'(DEG_MAX));
    k_next       = k + IW'(1);
    next_is_last = (CW'(k) + CW'(2)) == cnt;
  end

  // Collect/emit state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      cnt         <= '0;
      min1        <= MW'(31);
      min2        <= MW'(31);
      idx         <= '0;
      parity      <= 1'b0;
      sign_q      <= '0;
      k           <= '0;
      out_valid_q <= 1'b0;
      out_alpha_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            cnt    <= n_cnt;
            min1   <= n_min1;
            min2   <= n_min2;
            idx    <= n_idx;
            parity <= n_parity;
            sign_q <= n_sign;
            if (overflow) err_q <= 1'b1;
            if (done) begin
              state       <= EMIT;
              k           <= '0;
              out_valid_q <= 1'b1;
              out_alpha_q <= alpha_calc(n_idx == '0, n_parity ^ n_sign[0], n_min1, n_min2);
              out_last_q  <= (n_cnt == CW'(1));
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state       <= COLLECT;
              out_valid_q <= 1'b0;
              out_alpha_q <= '0;
              out_last_q  <= 1'b0;
              cnt         <= '0;
              min1        <= MW'(31);
              min2        <= MW'(31);
              idx         <= '0;
              parity      <= 1'b0;
              k           <= '0;
            end else begin
              k           <= k_next;
              out_alpha_q <= alpha_calc(k_next == idx, parity ^ sign_q[k_next], min1, min2);
              out_last_q  <= next_is_last;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_check_node_serial.sv
// Scoreboard bench for check_node_serial: OFFSET=0 and OFFSET=2 instances.
module tb_check_node_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic [5:0] in_beta;
  int         sel;

  logic       o_in_ready;
  logic       o_out_valid;
  logic [5:0] o_out_alpha;
  logic       o_out_last;
  logic       o_err;

  typedef struct packed {
    logic [5:0] alpha;
    logic       last;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  check_node_serial_if if0();
  check_node_serial_if if2();

  assign if0.in_valid  = in_valid && (sel == 0);
  assign if0.in_beta   = in_beta;
  assign if0.in_last   = in_last;
  assign if0.out_ready = out_ready;
  assign if2.in_valid  = in_valid && (sel == 1);
  assign if2.in_beta   = in_beta;
  assign if2.in_last   = in_last;
  assign if2.out_ready = out_ready;

  check_node_serial #(.DEG_MAX(8), .OFFSET(0)) u_off0 (.clk(clk), .rst(rst), .bus(if0));
  check_node_serial #(.DEG_MAX(8), .OFFSET(2)) u_off2 (.clk(clk), .rst(rst), .bus(if2));

  assign o_in_ready  = (sel == 0) ? if0.in_ready  : if2.in_ready;
  assign o_out_valid = (sel == 0) ? if0.out_valid : if2.out_valid;
  assign o_out_alpha = (sel == 0) ? if0.out_alpha : if2.out_alpha;
  assign o_out_last  = (sel == 0) ? if0.out_last  : if2.out_last;
  assign o_err       = (sel == 0) ? if0.err       : if2.err;

  // Output monitor: pops the scoreboard on every alpha handshake
  always @(negedge clk) begin
    if (!rst && o_out_valid) begin
      vectors++;
      if (o_in_ready !== 1'b0) begin
        $display("FAIL in_ready_during_emit got=%b want=0", o_in_ready);
        miscompares++;
      end
      if (out_ready) begin
        vectors++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_alpha got=%b last=%b want=none", o_out_alpha, o_out_last);
          miscompares++;
        end else begin
          e = sbq.pop_front();
          if ({o_out_alpha, o_out_last} !== {e.alpha, e.last}) begin
            $display("FAIL alpha got=%b last=%b want=%b last=%b",
                     o_out_alpha, o_out_last, e.alpha, e.last);
            miscompares++;
          end
        end
      end
    end
  end

  function automatic int beta_mag(input logic [5:0] b);
    int v;
    v = int'($signed(b));
    if (v < 0) v = -v;
    if (v > 31) v = 31;
    return v;
  endfunction

  // Reference: alpha_k = sign-product and minimum over every other edge
  task automatic push_expected(input logic [5:0] b[$], input int off);
    int   n;
    int   m;
    int   mo;
    logic s;
    exp_t x;
    n = b.size();
    for (int kk = 0; kk < n; kk++) begin
      m = 31;
      s = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (j != kk) begin
          if (beta_mag(b[j]) < m) m = beta_mag(b[j]);
          s = s ^ b[j][5];
        end
      end
      mo = (m > off) ? m - off : 0;
      x.alpha = 6'(s ? -mo : mo);
      x.last  = (kk == n - 1);
      sbq.push_back(x);
    end
  endtask

  task automatic send_eq(input logic [5:0] b[$], input logic mark_last, input int off);
    int n;
    int w;
    n = b.size();
    push_expected(b, off);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_beta  = b[i];
      in_last  = mark_last && (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!o_in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!o_in_ready) begin
        $display("FAIL in_ready_timeout got=%b want=1", o_in_ready);
        miscompares++;
        vectors++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    vectors++;
    if (o_out_valid !== 1'b1) begin
      $display("FAIL first_alpha_latency got=%b want=1", o_out_valid);
      miscompares++;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sbq.size() != 0 || o_out_valid) && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    vectors++;
    if (sbq.size() != 0 || o_out_valid !== 1'b0) begin
      $display("FAIL drain pending=%0d out_valid=%b want=0/0", sbq.size(), o_out_valid);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 0; in_valid = 1'b0; in_last = 1'b0; in_beta = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({if0.in_ready, if0.out_valid, if0.out_alpha, if0.out_last, if0.err} !== 10'b0) begin
      $display("FAIL reset_off0 got=%b want=0", {if0.in_ready, if0.out_valid, if0.out_alpha, if0.out_last, if0.err});
      miscompares++;
    end
    vectors++;
    if ({if2.in_ready, if2.out_valid, if2.out_alpha, if2.out_last, if2.err} !== 10'b0) begin
      $display("FAIL reset_off2 got=%b want=0", {if2.in_ready, if2.out_valid, if2.out_alpha, if2.out_last, if2.err});
      miscompares++;
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_in_ready !== 1'b1) begin
      $display("FAIL reset_release_in_ready got=%b want=1", o_in_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_degree3();
    logic [5:0] b[$];
    sel = 0;
    b = '{6'b001000, 6'b111100, 6'b001100};
    send_eq(b, 1'b1, 0);
    drain();
  endtask

  task automatic test_saturation();
    logic [5:0] b[$];
    sel = 0;
    b = '{6'b100000, 6'b010100};
    send_eq(b, 1'b1, 0);
    drain();
  endtask

  task automatic test_offset_degree1();
    logic [5:0] b[$];
    sel = 1;
    b = '{6'b000001, 6'b000011};
    send_eq(b, 1'b1, 2);
    drain();
    sel = 0;
    b = '{6'b000101};
    send_eq(b, 1'b1, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [5:0] b[$];
    int d;
    sel = 0;
    for (int eq = 0; eq < 6; eq++) begin
      b = {};
      d = int'($urandom_range(2, 8));
      for (int i = 0; i < d; i++) b.push_back(6'($urandom));
      send_eq(b, 1'b1, 0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [5:0] b[$];
    logic       pat[6];
    logic [6:0] held;
    logic       prev_stall;
    int         hs;
    sel = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    b = '{6'b001000, 6'b111100, 6'b001100};
    out_ready = 1'b1;
    send_eq(b, 1'b1, 0);
    hs = 0;
    prev_stall = 1'b0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if ({o_out_alpha, o_out_last} !== held) begin
          $display("FAIL stall_hold got=%b want=%b", {o_out_alpha, o_out_last}, held);
          miscompares++;
        end
      end
      if (o_out_valid && out_ready) hs++;
      prev_stall = o_out_valid && !out_ready;
      held = {o_out_alpha, o_out_last};
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    vectors++;
    if (hs != 3 || o_out_valid !== 1'b0) begin
      $display("FAIL backpressure_handshakes got=%0d valid=%b want=3 valid=0", hs, o_out_valid);
      miscompares++;
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [5:0] b[$];
    sel = 0;
    b = {};
    for (int i = 0; i < 8; i++) b.push_back(6'b000100);
    send_eq(b, 1'b0, 0);
    vectors++;
    if (o_err !== 1'b1) begin
      $display("FAIL overflow_err got=%b want=1", o_err);
      miscompares++;
    end
    drain();
    b = '{6'b001000, 6'b111100, 6'b001100};
    send_eq(b, 1'b1, 0);
    drain();
    vectors++;
    if (o_err !== 1'b1) begin
      $display("FAIL err_sticky got=%b want=1", o_err);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] b[$];
    sel = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_beta  = 6'b000011;
      in_last  = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_in_ready !== 1'b0) begin
      $display("FAIL mid_reset_in_ready got=%b want=0", o_in_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({o_out_valid, o_err} !== 2'b00) begin
      $display("FAIL mid_reset_state got=%b want=00", {o_out_valid, o_err});
      miscompares++;
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_in_ready !== 1'b1) begin
      $display("FAIL mid_reset_release got=%b want=1", o_in_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    b = '{6'b001000, 6'b111100, 6'b001100};
    send_eq(b, 1'b1, 0);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_degree3();
    test_saturation();
    test_offset_degree1();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
